// File: rtl/ex_alu_branch_unit.sv
`default_nettype none
// ============================================================================
// Module  : ex_alu_branch_unit
// Brief   : Execute-stage 32-bit ALU with Z/N/C/V flags, branch condition
//           evaluator and branch target adder. Combinational results feed
//           hazard/fetch-select logic and are registered at the EX/MEM edge.
// Rev     : 1.0  initial release
// ============================================================================
module ex_alu_branch_unit (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  cond,
  input  logic        branch_en,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  output logic [31:0] alu_out,
  output logic        z,
  output logic        n,
  output logic        c,
  output logic        v,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] alu_q,
  output logic [3:0]  flags_q,
  output logic        taken_q,
  output logic [31:0] target_q
);

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_AND    = 4'b0010;
  localparam logic [3:0] OP_OR     = 4'b0011;
  localparam logic [3:0] OP_XOR    = 4'b0100;
  localparam logic [3:0] OP_SLL    = 4'b0101;
  localparam logic [3:0] OP_SRL    = 4'b0110;
  localparam logic [3:0] OP_SRA    = 4'b0111;
  localparam logic [3:0] OP_SLT    = 4'b1000;
  localparam logic [3:0] OP_SLTU   = 4'b1001;
  localparam logic [3:0] OP_PASS_B = 4'b1010;
  localparam logic [3:0] OP_JALR   = 4'b1011;

  localparam logic [2:0] COND_BEQ  = 3'b000;
  localparam logic [2:0] COND_BNE  = 3'b001;
  localparam logic [2:0] COND_ALW  = 3'b010;
  localparam logic [2:0] COND_NEV  = 3'b011;
  localparam logic [2:0] COND_BLT  = 3'b100;
  localparam logic [2:0] COND_BGE  = 3'b101;
  localparam logic [2:0] COND_BLTU = 3'b110;
  localparam logic [2:0] COND_BGEU = 3'b111;

  localparam logic [31:0] JALR_MASK = 32'hFFFF_FFFE;

  logic [32:0] add_sum;
  logic [32:0] sub_sum;
  logic [4:0]  shamt;
  logic [31:0] res;
  logic        c_flag;
  logic        v_flag;
  logic        cond_true;

  logic [31:0] alu_d;
  logic [3:0]  flags_d;
  logic        taken_d;
  logic [31:0] target_d;

  // ALU result and carry/overflow; subtraction is a + ~b + 1 so carry means a >= b
  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b};
    sub_sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
    shamt   = b[4:0];
    res     = 32'd0;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res    = add_sum[31:0];
        c_flag = add_sum[32];
        v_flag = (a[31] == b[31]) && (add_sum[31] != a[31]);
      end
      OP_SUB: begin
        res    = sub_sum[31:0];
        c_flag = sub_sum[32];
        v_flag = (a[31] != b[31]) && (sub_sum[31] != a[31]);
      end
      OP_AND:    res = a & b;
      OP_OR:     res = a | b;
      OP_XOR:    res = a ^ b;
      OP_SLL:    res = a << shamt;
      OP_SRL:    res = a >> shamt;
      OP_SRA:    res = $unsigned($signed(a) >>> shamt);
      OP_SLT:    res = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU:   res = {31'd0, (a < b)};
      OP_PASS_B: res = b;
      OP_JALR:   res = add_sum[31:0] & JALR_MASK;
      default:   res = 32'd0;
    endcase
  end

  // Flag outputs, branch decision from flags, and the independent target adder
  always_comb begin
    alu_out = res;
    z       = (res == 32'd0);
    n       = res[31];
    c       = c_flag;
    v       = v_flag;
    case (cond)
      COND_BEQ:  cond_true = z;
      COND_BNE:  cond_true = !z;
      COND_ALW:  cond_true = 1'b1;
      COND_NEV:  cond_true = 1'b0;
      COND_BLT:  cond_true = n ^ v;
      COND_BGE:  cond_true = !(n ^ v);
      COND_BLTU: cond_true = !c;
      COND_BGEU: cond_true = c;
      default:   cond_true = 1'b0;
    endcase
    taken  = branch_en & cond_true;
    target = pc + imm;
  end

  // Next-state values for the EX/MEM register: plain capture, no enable or stall
  always_comb begin
    alu_d    = alu_out;
    flags_d  = {z, n, c, v};
    taken_d  = taken;
    target_d = target;
  end

  // EX/MEM boundary register, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_q    <= 32'd0;
      flags_q  <= 4'd0;
      taken_q  <= 1'b0;
      target_q <= 32'd0;
    end else begin
      alu_q    <= alu_d;
      flags_q  <= flags_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_branch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_alu_branch_unit
// Brief   : Self-checking bench for ex_alu_branch_unit: directed corner cases
//           plus randomized traffic against an arithmetic reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ex_alu_branch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a, b, pc, imm;
  logic [3:0]  alu_op;
  logic [2:0]  cond;
  logic        branch_en;
  logic [31:0] alu_out, target, alu_q, target_q;
  logic        z, n, c, v, taken, taken_q;
  logic [3:0]  flags_q;

  int tests_run = 0;
  int tests_failed = 0;

  // Packed view: {result, z, n, c, v, taken, target}
  typedef struct packed {
    logic [31:0] res;
    logic        z, n, c, v, taken;
    logic [31:0] target;
  } exp_t;

  logic [68:0] comb_v;
  logic [68:0] reg_v;
  assign comb_v = {alu_out, z, n, c, v, taken, target};
  assign reg_v  = {alu_q, flags_q, taken_q, target_q};

  ex_alu_branch_unit dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .alu_op(alu_op), .cond(cond),
    .branch_en(branch_en), .pc(pc), .imm(imm), .alu_out(alu_out),
    .z(z), .n(n), .c(c), .v(v), .taken(taken), .target(target),
    .alu_q(alu_q), .flags_q(flags_q), .taken_q(taken_q), .target_q(target_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;
  localparam longint UMOD = 64'sd4294967296;

  // Reference model from the arithmetic definitions of each operation
  function automatic exp_t model(input logic [31:0] fa, input logic [31:0] fb,
                                 input logic [3:0] op, input logic [2:0] fc,
                                 input logic br, input logic [31:0] fpc,
                                 input logic [31:0] fimm);
    exp_t e;
    longint ua, ub, sa, sb, s;
    int     sh;
    logic [31:0] ones;
    logic   t;
    ones = '1;
    ua = longint'({32'd0, fa});
    ub = longint'({32'd0, fb});
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    sh = int'(fb % 32);
    e = '0;
    case (op)
      4'd0: begin
        s = ua + ub; e.res = s[31:0]; e.c = (s >= UMOD);
        s = sa + sb; e.v = (s > SMAX) || (s < SMIN);
      end
      4'd1: begin
        s = ua - ub; e.res = s[31:0]; e.c = (ua >= ub);
        s = sa - sb; e.v = (s > SMAX) || (s < SMIN);
      end
      4'd2:  e.res = fa & fb;
      4'd3:  e.res = fa | fb;
      4'd4:  e.res = fa ^ fb;
      4'd5:  begin s = ua * (64'sd1 << sh); e.res = s[31:0]; end
      4'd6:  e.res = fa >> sh;
      4'd7:  e.res = (fa >> sh) | (fa[31] ? ~(ones >> sh) : 32'd0);
      4'd8:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  e.res = (ua < ub) ? 32'd1 : 32'd0;
      4'd10: e.res = fb;
      4'd11: begin s = (ua + ub) % UMOD; s = s - (s % 2); e.res = s[31:0]; end
      default: e.res = 32'd0;
    endcase
    e.z = (e.res == 0);
    e.n = e.res[31];
    case (fc)
      3'd0: t = e.z;
      3'd1: t = !e.z;
      3'd2: t = 1'b1;
      3'd3: t = 1'b0;
      3'd4: t = (e.n != e.v);
      3'd5: t = (e.n == e.v);
      3'd6: t = !e.c;
      default: t = e.c;
    endcase
    e.taken = br && t;
    s = (longint'({32'd0, fpc}) + longint'({32'd0, fimm})) % UMOD;
    e.target = s[31:0];
    return e;
  endfunction

  exp_t ex;

  // Apply a new operand set mid-cycle and let combinational logic settle
  task automatic drive(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [2:0] vc, input logic br,
                       input logic [31:0] vpc, input logic [31:0] vimm);
    @(negedge clk);
    alu_op = op; a = va; b = vb; cond = vc; branch_en = br; pc = vpc; imm = vimm;
    ex = model(va, vb, op, vc, br, vpc, vimm);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tests_run++;
    if (reg_v !== 69'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: regs=%h required 0", reg_v);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (reg_v !== 69'd0) begin
      tests_failed++;
      $display("FAIL reset_release_no_edge: regs=%h required 0", reg_v);
    end
  endtask

  task automatic test_add_overflow();
    drive(4'd0, 32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 32'd0, 32'd0);
    tests_run++;
    if ({alu_out, z, n, c, v} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL add_ovf: out=%h zncv=%b%b%b%b required 80000000 zncv=0101", alu_out, z, n, c, v);
    end
    tick();
    tests_run++;
    if (alu_q !== 32'h8000_0000 || flags_q !== 4'b0101) begin
      tests_failed++;
      $display("FAIL add_ovf_reg: alu_q=%h flags_q=%b required 80000000 0101", alu_q, flags_q);
    end
  endtask

  task automatic test_sub_branch();
    drive(4'd1, 32'd5, 32'd5, 3'd0, 1'b1, 32'h100, 32'h10);
    tests_run++;
    if (alu_out !== 32'd0 || z !== 1'b1 || c !== 1'b1 || taken !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub_beq: out=%h z=%b c=%b taken=%b required 0 1 1 1", alu_out, z, c, taken);
    end
    drive(4'd1, 32'd5, 32'd5, 3'd0, 1'b0, 32'h100, 32'h10);
    tests_run++;
    if (taken !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_beq_disabled: taken=%b required 0", taken);
    end
    tick();
    tests_run++;
    if (taken_q !== 1'b0 || flags_q !== 4'b1010) begin
      tests_failed++;
      $display("FAIL sub_beq_reg: taken_q=%b flags_q=%b required 0 1010", taken_q, flags_q);
    end
  endtask

  task automatic test_signed_unsigned();
    drive(4'd1, 32'hFFFF_FFFF, 32'd1, 3'd4, 1'b1, 32'd0, 32'd0);
    tests_run++;
    if (taken !== 1'b1) begin
      tests_failed++;
      $display("FAIL blt: taken=%b required 1", taken);
    end
    drive(4'd1, 32'hFFFF_FFFF, 32'd1, 3'd6, 1'b1, 32'd0, 32'd0);
    tests_run++;
    if (taken !== 1'b0) begin
      tests_failed++;
      $display("FAIL bltu: taken=%b required 0", taken);
    end
    drive(4'd8, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0, 32'd0, 32'd0);
    tests_run++;
    if (alu_out !== 32'd1) begin
      tests_failed++;
      $display("FAIL slt: out=%h required 1", alu_out);
    end
    drive(4'd9, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0, 32'd0, 32'd0);
    tests_run++;
    if (alu_out !== 32'd0 || z !== 1'b1) begin
      tests_failed++;
      $display("FAIL sltu: out=%h z=%b required 0 1", alu_out, z);
    end
  endtask

  task automatic test_shifts();
    logic [31:0] req [4];
    logic [3:0]  ops [4];
    logic [31:0] bs  [4];
    ops = '{4'd7, 4'd6, 4'd5, 4'd7};
    bs  = '{32'd4, 32'd4, 32'd4, 32'h24};
    req = '{32'hF800_0000, 32'h0800_0000, 32'h0, 32'hF800_0000};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 32'h8000_0000, bs[i], 3'd0, 1'b0, 32'd0, 32'd0);
      tests_run++;
      if (alu_out !== req[i] || z !== (req[i] == 32'd0)) begin
        tests_failed++;
        $display("FAIL shift_%0d: out=%h z=%b required %h", i, alu_out, z, req[i]);
      end
    end
  endtask

  task automatic test_target_jalr();
    drive(4'd11, 32'h101, 32'd2, 3'd2, 1'b1, 32'hFFFF_FFFC, 32'd8);
    tests_run++;
    if (target !== 32'h4 || alu_out !== 32'h102 || taken !== 1'b1) begin
      tests_failed++;
      $display("FAIL target_jalr: target=%h out=%h taken=%b required 4 102 1", target, alu_out, taken);
    end
    tick();
    tests_run++;
    if (target_q !== 32'h4 || alu_q !== 32'h102) begin
      tests_failed++;
      $display("FAIL target_jalr_reg: target_q=%h alu_q=%h required 4 102", target_q, alu_q);
    end
  endtask

  task automatic test_async_reset();
    drive(4'd0, 32'd1, 32'd2, 3'd2, 1'b1, 32'h1000, 32'h20);
    tick();
    tests_run++;
    if (reg_v !== ex) begin
      tests_failed++;
      $display("FAIL areset_load: regs=%h required %h", reg_v, ex);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (reg_v !== 69'd0 || comb_v !== ex) begin
      tests_failed++;
      $display("FAIL areset_immediate: regs=%h comb=%h required 0 and %h", reg_v, comb_v, ex);
    end
    tick();
    tests_run++;
    if (reg_v !== 69'd0) begin
      tests_failed++;
      $display("FAIL areset_hold_edge: regs=%h required 0", reg_v);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (reg_v !== 69'd0) begin
      tests_failed++;
      $display("FAIL areset_release: regs=%h required 0", reg_v);
    end
    tick();
    tests_run++;
    if (reg_v !== ex) begin
      tests_failed++;
      $display("FAIL areset_resume: regs=%h required %h", reg_v, ex);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [31:0] ra, rb;
    logic [3:0]  op;
    exp_t        prev;
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      if (i % 3 == 0) op = 4'd1;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
      if ($urandom_range(0, 4) == 0) rb = {ra[31:1], ~ra[0]};
      drive(op, ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom, $urandom);
      tests_run++;
      if (comb_v !== ex) begin
        tests_failed++;
        $display("FAIL rand_comb_%0d: op=%h a=%h b=%h cond=%0d br=%b got=%h required %h",
                 i, alu_op, a, b, cond, branch_en, comb_v, ex);
      end
      prev = ex;
      tick();
      tests_run++;
      if (reg_v !== prev) begin
        tests_failed++;
        $display("FAIL rand_reg_%0d: got=%h required %h", i, reg_v, prev);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    a = '0; b = '0; pc = '0; imm = '0; alu_op = '0; cond = '0; branch_en = 1'b0;
    test_reset();
    test_add_overflow();
    test_sub_branch();
    test_signed_unsigned();
    test_shifts();
    test_target_jalr();
    test_async_reset();
    test_random_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
